// File: rtl/cpu_clock_control_if.sv
// Purpose: bundles the clock-control handshake signals between the environment and the block.
// Latency: none (wires only).
// Backpressure: none; cpu_enable is a strobe that the core must take on the cycle it is high.
interface cpu_clock_control_if #(
   parameter int COUNT_WIDTH = 16
);
   logic                   divided_clock;
   logic                   step_button;
   logic                   run_switch;
   logic                   halt_request;
   logic                   cpu_enable;
   logic [1:0]             mode;
   logic [COUNT_WIDTH-1:0] enable_count;

   // Environment side: drives the raw inputs and observes the enable strobe.
   modport master (
      output divided_clock,
      output step_button,
      output run_switch,
      output halt_request,
      input  cpu_enable,
      input  mode,
      input  enable_count
   );

   // Clock-control block side.
   modport slave (
      input  divided_clock,
      input  step_button,
      input  run_switch,
      input  halt_request,
      output cpu_enable,
      output mode,
      output enable_count
   );
endinterface

// File: rtl/cpu_clock_control.sv
// Purpose: turns divided_clock rises or debounced step presses into a one-cycle core clock enable.
// Latency: divided_clock sampled high at edge k -> cpu_enable after edge k+2; step_pulse -> cpu_enable next edge.
// Backpressure: none; pulses are strobes, never held or queued. Macro CPU_CLOCK_CONTROL_COUNT_EN builds enable_count.
module cpu_clock_control #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DEBOUNCE_WIDTH  = 19,
   parameter int COUNT_WIDTH     = 16
) (
   input logic              clock_50mhz,
   input logic              reset,
   cpu_clock_control_if.slave ctl
);

   typedef enum logic [1:0] {
      ST_STOPPED = 2'b00,
      ST_RUNNING = 2'b01,
      ST_HALTED  = 2'b10
   } state_t;

   // Counter value at which the input has been stable long enough to accept.
   localparam logic [DEBOUNCE_WIDTH-1:0] DEB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                      div_s1;
   logic                      div_s2;
   logic                      div_s3;
   logic                      tick;

   logic                      btn_s1;
   logic                      btn_s2;
   logic                      deb_level;
   logic [DEBOUNCE_WIDTH-1:0] deb_cnt;
   logic                      step_pulse;

   state_t                    state;
   state_t                    state_next;
   logic                      cpu_enable_q;
   logic                      cpu_enable_next;

   // Synchronize divided_clock and keep one history flop for rising-edge detection.
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         div_s1 <= 1'b0;
         div_s2 <= 1'b0;
         div_s3 <= 1'b0;
      end else begin
         div_s1 <= ctl.divided_clock;
         div_s2 <= div_s1;
         div_s3 <= div_s2;
      end
   end

   // Only rising edges of the divided clock produce a tick.
   assign tick = div_s2 & ~div_s3;

   // Synchronize the raw push button before it reaches the debouncer.
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= ctl.step_button;
         btn_s2 <= btn_s1;
      end
   end

   // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles; pulse on press only.
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         deb_level  <= 1'b0;
         deb_cnt    <= '0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         if (btn_s2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level  <= ~deb_level;
            deb_cnt    <= '0;
            // A flip from 0 is a press; a flip from 1 is a release and stays silent.
            step_pulse <= ~deb_level;
         end else begin
            deb_cnt <= deb_cnt + DEBOUNCE_WIDTH'(1);
         end
      end
   end

   // Register the mode state and the enable strobe.
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         state        <= ST_STOPPED;
         cpu_enable_q <= 1'b0;
      end else begin
         state        <= state_next;
         cpu_enable_q <= cpu_enable_next;
      end
   end

   // Select the enable source per mode; halt outranks run and suppresses a coincident tick.
   always_comb begin
      state_next      = state;
      cpu_enable_next = 1'b0;
      case (state)
         ST_STOPPED: begin
            cpu_enable_next = step_pulse;
            if (ctl.halt_request) begin
               state_next = ST_HALTED;
            end else if (ctl.run_switch) begin
               state_next = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            if (ctl.halt_request) begin
               state_next = ST_HALTED;
            end else begin
               // A tick arriving as the switch drops is still delivered.
               cpu_enable_next = tick;
               if (!ctl.run_switch) begin
                  state_next = ST_STOPPED;
               end
            end
         end
         ST_HALTED: begin
            if (!ctl.halt_request && !ctl.run_switch) begin
               state_next = ST_STOPPED;
            end
         end
         default: begin
            state_next = ST_STOPPED;
         end
      endcase
      // A step pulse followed by a tick across a STOPPED->RUNNING change could otherwise
      // give two adjacent enables; the core must always see isolated strobes.
      if (cpu_enable_q) begin
         cpu_enable_next = 1'b0;
      end
   end

   assign ctl.cpu_enable = cpu_enable_q;
   assign ctl.mode       = state;

`ifdef CPU_CLOCK_CONTROL_COUNT_EN
   logic [COUNT_WIDTH-1:0] enable_count_q;

   // Count issued enables; natural overflow provides the wrap to zero.
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         enable_count_q <= '0;
      end else if (cpu_enable_q) begin
         enable_count_q <= enable_count_q + COUNT_WIDTH'(1);
      end
   end

   assign ctl.enable_count = enable_count_q;
`else
   assign ctl.enable_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/cpu_clock_control.md
Name: cpu_clock_control

Overview:
- Sits directly downstream of the frequency divider; consumes its slow divided_clock square wave.
- Produces a single-cycle clock-enable pulse in the clock_50mhz domain for the processor core.
- Selects one of three sources for that pulse: free-run at the divided rate, manual single-step from a push button, or halted.
- Keeps the whole core on one clock; no logic is ever clocked by divided_clock itself.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new step_button level (10 ms at 50 MHz).
DEBOUNCE_WIDTH, 19, width of the debounce counter; must satisfy 2**DEBOUNCE_WIDTH > DEBOUNCE_CYCLES.
COUNT_WIDTH, 16, width of enable_count.

Ports:
clock_50mhz  input  1  system clock, sole clock of the block
reset  input  1  synchronous, active-high reset
divided_clock  input  1  slow square wave from the frequency divider; asynchronous to this block's logic
step_button  input  1  raw push button, active-high, bouncing
run_switch  input  1  1 = free-run mode requested, 0 = step mode; static slide switch
halt_request  input  1  core has executed a halt; level
cpu_enable  output  1  one-cycle clock-enable pulse to the core
mode  output  2  00 STOPPED, 01 RUNNING, 10 HALTED
enable_count  output  COUNT_WIDTH  number of cpu_enable pulses issued (optional feature)

Behaviour:
- Clock and reset: one clock, clock_50mhz. reset is synchronous and active-high.
- Reset values: all synchronizer flops 0, debounced level 0, debounce counter 0, state STOPPED, cpu_enable 0, mode 00, enable_count 0.
- Reset mid-operation: the block is in STOPPED on the cycle after reset is sampled. Any pending tick or step pulse is dropped.
- divided_clock path:
  - 2-flop synchronizer s1 -> s2, plus history flop s3.
  - tick = s2 & ~s3.
  - Only rising edges matter.
- step_button path:
  - 2-flop synchronizer feeds the debouncer.
  - Counter increments while the synchronized input differs from the debounced level. It clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - step_pulse = one cycle, on the 0->1 transition of the debounced level only. Release generates nothing.
- FSM (registered state):
  - STOPPED:
    - cpu_enable <= step_pulse.
    - run_switch=1 -> RUNNING.
    - halt_request=1 -> HALTED; halt takes priority over run_switch.
  - RUNNING:
    - cpu_enable <= tick.
    - halt_request=1 -> HALTED, and cpu_enable <= 0 that cycle even if tick=1.
    - Else if run_switch=0 -> STOPPED; a coincident tick is still issued.
  - HALTED:
    - cpu_enable <= 0. Ticks and steps are ignored.
    - Exits to STOPPED only when halt_request=0 and run_switch=0. Otherwise stays.
- Latency:
  - divided_clock first sampled high at edge k -> tick high after edge k+1 -> cpu_enable high for exactly one cycle after edge k+2.
  - step_pulse -> cpu_enable on the next edge, 1 cycle.
- cpu_enable is never high on two consecutive cycles.
- mode mirrors the registered state with no extra delay.
- enable_count increments by 1 on every cycle cpu_enable=1. It wraps from 2**COUNT_WIDTH-1 to 0.

Optional Feature:
CPU_CLOCK_CONTROL_COUNT_EN
- Defined: enable_count is implemented as specified above.
- Undefined: no counter register is built and enable_count is tied to 0; the port remains present.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, run_switch=1, divided_clock toggling every 8 cycles:
  - mode goes 00 -> 01.
  - cpu_enable is a 1-cycle pulse every 16 cycles, 3 cycles after each divided_clock rise.
  - enable_count = 4 after 4 rises.
- run_switch=0, step_button bounce 1,0,1 then held high for 10 cycles:
  - exactly one cpu_enable pulse.
  - no pulse on release.
  - divided_clock activity produces no pulses.
- RUNNING with halt_request asserted on the same cycle as a tick:
  - no cpu_enable.
  - mode=10.
  - later presses and ticks give no pulses.
  - mode returns to 00 only after halt_request=0 and run_switch=0.
- With the feature macro defined, preload 65535 pulses (or force the counter to 16'hFFFF):
  - one more pulse gives enable_count = 0.
- Assert reset for 1 cycle during RUNNING, one cycle before an expected pulse:
  - no pulse.
  - mode=00 and enable_count=0 on the next cycle.
- Compile without the macro:
  - enable_count stays 0 throughout the first scenario.
